// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage in front of a synchronous single-port ROM. It issues
// one ROM read per cycle while decode keeps accepting, so the throughput is one
// instruction per cycle. It follows branch/jump/trap redirects. Any fetch
// target that is misaligned or outside the ROM window becomes a fault beat.
// After a fault beat the stage halts until the next redirect.
//
// Ports
//   clk              single clock, all state on the rising edge
//   rst              synchronous, active-high reset
//   rom_rd_en        ROM read-port enable
//   rom_addr         ROM word address of the fetch being issued
//   rom_rd_data      ROM registered read data, valid one cycle after rom_rd_en
//   redirect_en      redirect strobe, beats both stall and sequential fetch
//   redirect_pc      redirect byte target
//   out_valid        instruction beat valid to decode
//   out_ready        decode accepts the beat (transfer = out_valid & out_ready)
//   out_inst         instruction word (NOP 0x13 on fault beats)
//   out_pc           byte PC of out_inst
//   out_misaligned   beat is an instruction-address-misaligned fault
//   out_access_fault beat is an instruction-access fault (outside ROM window)
// ----------------------------------------------------------------------------

package instr_fetch_pkg;
    // Word-address width of the attached ROM.
    localparam int DEFAULT_ROM_ADDR_WIDTH = 10;
endpackage

module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          ADDR_WIDTH = DEFAULT_ROM_ADDR_WIDTH,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] ROM_BASE   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  rom_rd_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]           rom_rd_data,
    input  logic                  redirect_en,
    input  logic [31:0]           redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_inst,
    output logic [31:0]           out_pc,
    output logic                  out_misaligned,
    output logic                  out_access_fault
);

    localparam logic [0:0]  MODE_RUN  = 1'b0;
    localparam logic [0:0]  MODE_HALT = 1'b1;
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    // Address bits that must match ROM_BASE for an address to be inside the window.
    localparam logic [31:0] WINDOW_MASK = ~((32'd1 << (ADDR_WIDTH + 2)) - 32'd1);

    logic [31:0] pc_q,         pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_pc_q,    resp_pc_d;
    logic [1:0]  resp_fault_q, resp_fault_d;   // {access_fault, misaligned}
    logic [0:0]  mode_q,       mode_d;

    logic        advance;
    logic        fetch_seq;
    logic        fetch_any;
    logic [31:0] fetch_addr;
    logic        fetch_mis;
    logic        fetch_oow;
    logic        fetch_legal;

    // Reset is synchronous, so the beat registers still hold old values during
    // the first reset cycle. Masking here hides them at once.
    assign out_valid = resp_valid_q & ~rst;
    assign advance   = ~out_valid | out_ready;

    // A redirect takes priority over both stall and HALT. It also drops any
    // beat that is not accepted in the same cycle.
    assign fetch_seq = ~rst & ~redirect_en & (mode_q == MODE_RUN) & advance;
    assign fetch_any = (~rst & redirect_en) | fetch_seq;

    assign fetch_addr  = redirect_en ? redirect_pc : pc_q;
    assign fetch_mis   = (fetch_addr[1:0] != 2'b00);
    assign fetch_oow   = (((fetch_addr ^ ROM_BASE) & WINDOW_MASK) != 32'd0);
    assign fetch_legal = ~fetch_mis & ~fetch_oow;

    assign rom_rd_en = fetch_any & fetch_legal;
    assign rom_addr  = fetch_addr[ADDR_WIDTH+1:2];

    // During a stall the ROM output stays valid because no new read is issued.
    // This lets out_inst come straight from the ROM without a local copy.
    assign out_pc           = resp_pc_q;
    assign out_inst         = (resp_fault_q != 2'b00) ? NOP_INST : rom_rd_data;
    assign out_misaligned   = out_valid & resp_fault_q[0];
    assign out_access_fault = out_valid & resp_fault_q[1];

    always_comb begin
        // NOTE: every next-state signal gets a default before any branch, so
        // paths that do not assign it keep the value and infer no latch.
        pc_d         = pc_q;
        resp_valid_d = resp_valid_q;
        resp_pc_d    = resp_pc_q;
        resp_fault_d = resp_fault_q;
        mode_d       = mode_q;

        if (fetch_any) begin
            resp_valid_d = 1'b1;
            resp_pc_d    = fetch_addr;
            // Misaligned wins, so at most one flag is set.
            resp_fault_d = {~fetch_mis & fetch_oow, fetch_mis};
            if (fetch_legal) begin
                pc_d   = fetch_addr + 32'd4;
                mode_d = MODE_RUN;
            end else begin
                mode_d = MODE_HALT;
            end
        end else if (advance) begin
            // This branch is reached only in HALT: the held beat (if any) was
            // taken this cycle, and nothing replaces it.
            resp_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_ADDR;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= RESET_ADDR;
            resp_fault_q <= 2'b00;
            mode_q       <= MODE_RUN;
        end else begin
            pc_q         <= pc_d;
            resp_valid_q <= resp_valid_d;
            resp_pc_q    <= resp_pc_d;
            resp_fault_q <= resp_fault_d;
            mode_q       <= mode_d;
        end
    end

endmodule
